// File: rtl/iter_div_unit_if.sv
// Operand/result bundle for iter_div_unit. The master drives the request and the
// slave drives status and results.
interface iter_div_unit_if #(parameter int n = 32);
  // Handshake: start is taken only while the unit is idle, together with signed_op,
  // dividend and divisor. busy stays high from the cycle after acceptance through the
  // done cycle. done pulses for one cycle. quotient, remainder, dz, V and Z are valid
  // with done and hold their values until the next accepted start.
  logic         start;
  logic         signed_op;
  logic [n-1:0] dividend;
  logic [n-1:0] divisor;
  logic         busy;
  logic         done;
  logic [n-1:0] quotient;
  logic [n-1:0] remainder;
  logic         dz;
  logic         V;
  logic         Z;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, dz, V, Z
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, dz, V, Z
  );
endinterface

// File: rtl/iter_div_unit.sv
// Iterative restoring divider: one quotient bit per cycle, signed or unsigned,
// with divide-by-zero and signed-overflow flags.
module iter_div_unit #(
  parameter int n = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  iter_div_unit_if.slave    bus,
  output logic [1:0]        dbg_state
);
  localparam int CW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] C_ONE = 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [n:0]    rem;
  logic [n-1:0]  qw;
  logic [n-1:0]  dvs_mag;
  logic          neg_q;
  logic          neg_r;
  logic          ovf;

  logic [n-1:0]  dvd_abs;
  logic [n-1:0]  dvs_abs;
  logic [n:0]    shifted;
  logic [n+1:0]  sub_sum;
  logic          no_borrow;
  logic [n-1:0]  q_fix;
  logic [n-1:0]  r_fix;

  assign dbg_state = state;

  always_comb begin
    dvd_abs = bus.dividend;
    dvs_abs = bus.divisor;
    if (bus.signed_op && bus.dividend[n-1]) dvd_abs = -bus.dividend;
    if (bus.signed_op && bus.divisor[n-1])  dvs_abs = -bus.divisor;
    // Subtract as add-with-inverted-operand and carry-in; carry out means no borrow.
    shifted   = {rem[n-1:0], qw[n-1]};
    sub_sum   = {1'b0, shifted} + {1'b0, ~{1'b0, dvs_mag}} + (n+2)'(1);
    no_borrow = sub_sum[n+1];
    q_fix     = neg_q ? -qw : qw;
    r_fix     = neg_r ? -rem[n-1:0] : rem[n-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= '0;
      rem           <= '0;
      qw            <= '0;
      dvs_mag       <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      ovf           <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.dz        <= 1'b0;
      bus.V         <= 1'b0;
      bus.Z         <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          bus.busy <= bus.start;
          if (bus.start) begin
            if (bus.divisor == '0) begin
              bus.quotient  <= '1;
              bus.remainder <= bus.dividend;
              bus.dz        <= 1'b1;
              bus.V         <= 1'b0;
              bus.Z         <= 1'b0;
              state         <= DONE;
            end else begin
              qw      <= dvd_abs;
              rem     <= '0;
              dvs_mag <= dvs_abs;
              neg_q   <= bus.signed_op && (bus.dividend[n-1] ^ bus.divisor[n-1]);
              neg_r   <= bus.signed_op && bus.dividend[n-1];
              ovf     <= bus.signed_op && (bus.dividend == {1'b1, {(n-1){1'b0}}})
                         && (bus.divisor == '1);
              count   <= CW'(n - 1);
              state   <= DIV;
            end
          end
        end
        DIV: begin
          rem <= no_borrow ? sub_sum[n:0] : shifted;
          qw  <= {qw[n-2:0], no_borrow};
          if (count == '0) state <= FIX;
          else             count <= count - C_ONE;
        end
        FIX: begin
          bus.quotient  <= q_fix;
          bus.remainder <= r_fix;
          bus.Z         <= (q_fix == '0);
          bus.V         <= ovf;
          bus.dz        <= 1'b0;
          state         <= DONE;
        end
        DONE: begin
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_div_unit.sv
// Bench for iter_div_unit: directed cases, randomized operands against an
// arithmetic reference, start-ignore, back-to-back and reset-abort scenarios.
module tb_iter_div_unit;
  localparam int N = 32;
  localparam logic [N-1:0] MOST_NEG = 32'h8000_0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;
  logic [N-1:0] exp_q[$];

  iter_div_unit_if #(.n(N)) bus();

  iter_div_unit #(.n(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division; SV signed division truncates toward zero.
  function automatic void model(input bit s, input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] q, output logic [N-1:0] r);
    longint sa, sb, lq, lr;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[N-1:0];
      r  = lr[N-1:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!bus.done && cyc < 80);
  endtask

  task automatic drive_idle();
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
  endtask

  task automatic run_div(input bit s, input logic [N-1:0] a, input logic [N-1:0] b,
                         input string tag);
    logic [N-1:0] eq, er, got;
    int cyc, exp_lat;
    bit exp_v, exp_z;
    model(s, a, b, eq, er);
    exp_q.push_back(eq);
    exp_q.push_back(er);
    exp_lat = (b == '0) ? 1 : N + 2;
    exp_v   = s && a == MOST_NEG && b == '1;
    exp_z   = (b != '0) && (eq == '0);
    bus.start = 1'b1; bus.signed_op = s; bus.dividend = a; bus.divisor = b;
    tick();
    bus.start = 1'b0; bus.signed_op = ~s; bus.dividend = $urandom; bus.divisor = $urandom;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start got=%b exp=1", tag, bus.busy);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== exp_lat) begin
      errors++; $display("FAIL %s latency got=%0d exp=%0d", tag, cyc, exp_lat);
    end
    got = exp_q.pop_front();
    checks++;
    if (bus.quotient !== got) begin
      errors++; $display("FAIL %s quotient got=%h exp=%h", tag, bus.quotient, got);
    end
    got = exp_q.pop_front();
    checks++;
    if (bus.remainder !== got) begin
      errors++; $display("FAIL %s remainder got=%h exp=%h", tag, bus.remainder, got);
    end
    checks++;
    if ({bus.dz, bus.V, bus.Z} !== {(b == '0), exp_v, exp_z}) begin
      errors++; $display("FAIL %s flags dz,V,Z got=%b%b%b exp=%b%b%b", tag,
                         bus.dz, bus.V, bus.Z, (b == '0), exp_v, exp_z);
    end
    tick();
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL %s done_busy_after got=%b%b exp=00", tag, bus.done, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd5; bus.divisor = 32'd0;
    repeat (3) tick();
    checks++;
    if ({bus.busy, bus.done, bus.dz, bus.V, bus.Z, bus.quotient, bus.remainder, dbg_state} !== '0) begin
      errors++; $display("FAIL reset_state busy=%b done=%b q=%h r=%h st=%0d exp=all0",
                         bus.busy, bus.done, bus.quotient, bus.remainder, dbg_state);
    end
    drive_idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    run_div(1'b0, 32'd100, 32'd7, "u100_7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "s-7_2");
    run_div(1'b1, MOST_NEG, 32'hFFFF_FFFF, "s_ovf");
    run_div(1'b0, 32'd5, 32'd0, "u5_0");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, "s7_-2");
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, "umax_1");
  endtask

  task automatic test_random();
    bit s;
    logic [N-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = (i % 6 == 5) ? MOST_NEG : $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = '1;
        default: b = $urandom;
      endcase
      run_div(s, a, b, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd3; bus.divisor = 32'd9;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.start = 1'b1; bus.dividend = 32'd8; bus.divisor = 32'd2;
    tick();
    bus.start = 1'b0;
    wait_done(cyc);
    cyc += 10;
    checks++;
    if (cyc !== N + 2) begin
      errors++; $display("FAIL ignore latency got=%0d exp=%0d", cyc, N + 2);
    end
    checks++;
    if ({bus.quotient, bus.remainder, bus.Z} !== {32'd0, 32'd3, 1'b1}) begin
      errors++; $display("FAIL ignore result q=%h r=%h Z=%b exp q=0 r=3 Z=1",
                         bus.quotient, bus.remainder, bus.Z);
    end
    tick();
    run_div(1'b0, 32'd8, 32'd2, "after_ignore");
  endtask

  task automatic test_back_to_back();
    int cyc;
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    tick();
    bus.signed_op = 1'b1; bus.dividend = 32'hFFFF_FFCE; bus.divisor = 32'd7;
    wait_done(cyc);
    checks++;
    if (cyc !== N + 2) begin
      errors++; $display("FAIL b2b first_latency got=%0d exp=%0d", cyc, N + 2);
    end
    checks++;
    if ({bus.quotient, bus.remainder} !== {32'd333, 32'd1}) begin
      errors++; $display("FAIL b2b first_result q=%h r=%h exp q=14d r=1", bus.quotient, bus.remainder);
    end
    tick();
    bus.start = 1'b0;
    checks++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      errors++; $display("FAIL b2b second_accept busy,done got=%b%b exp=10", bus.busy, bus.done);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== N + 2) begin
      errors++; $display("FAIL b2b second_latency got=%0d exp=%0d", cyc, N + 2);
    end
    // -50 / 7 truncates to -7 remainder -1
    checks++;
    if ({bus.quotient, bus.remainder} !== {32'hFFFF_FFF9, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL b2b second_result q=%h r=%h exp q=fffffff9 r=ffffffff",
                         bus.quotient, bus.remainder);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.dz, bus.V, bus.Z, bus.quotient, bus.remainder, dbg_state} !== '0) begin
      errors++; $display("FAIL reset_mid state busy=%b done=%b q=%h r=%h st=%0d exp=all0",
                         bus.busy, bus.done, bus.quotient, bus.remainder, dbg_state);
    end
    rst_n = 1'b1;
    repeat (40) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid no_done got done_seen=%b busy=%b exp=0 0", seen, bus.busy);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
